// File: rtl/reg_dump_sequencer.sv
// ---------------------------------------------------------------------------
// reg_dump_sequencer
//
// Purpose:
//   Debug read-out controller for the decode-stage register bank. Once the
//   pipeline is halted and a dump is requested, it drives the bank's debug
//   read port and walks registers 0..N_REGS-1. Each NB_DATA-bit word is sent
//   to the debug UART transmitter as NB_BYTE-bit bytes, MSB first, over a
//   valid/ready handshake.
//
// Ports:
//   i_clock      clock
//   i_reset      synchronous, active-high reset
//   i_start      dump request, only looked at while idle
//   i_halted     pipeline halted; a dump starts only if this is high
//   i_abort      cancels a dump in progress (no done pulse)
//   i_reg_data   register bank debug read data
//   o_br_enable  selects the debug address on bank read port A
//   o_br_addr    register index being read
//   o_tx_data    byte to the transmitter
//   o_tx_valid   o_tx_data is valid
//   i_tx_ready   transmitter accepts the byte this cycle
//   o_busy       dump in progress
//   o_done       one-cycle pulse when a dump completes
//
// Optional feature (macro REG_DUMP_CHECKSUM_EN):
//   When defined, a running XOR of every transmitted data byte is kept and
//   sent as one extra byte after the last register, before the done pulse.
//   When undefined there is no checksum state and no accumulator.
// ---------------------------------------------------------------------------
module reg_dump_sequencer #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int N_REGS  = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_halted,
  input  logic               i_abort,
  input  logic [NB_DATA-1:0] i_reg_data,
  output logic               o_br_enable,
  output logic [NB_REG-1:0]  o_br_addr,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NB_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_IDX   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(NB_BYTES - 1);
  localparam logic [NB_REG-1:0] LAST_REG = NB_REG'(N_REGS - 1);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CAPTURE,
    ST_SEND,
    ST_CHKSUM,
    ST_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CAPTURE,
    ST_SEND,
    ST_DONE
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [NB_REG-1:0]    addr_q,  addr_d;
  logic [NB_DATA-1:0]   shift_q, shift_d;
  logic [NB_IDX-1:0]    idx_q,   idx_d;
  logic [NB_BYTE-1:0]   topByte;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0]   chk_q,   chk_d;
`endif

  assign topByte = shift_q[NB_DATA-1 -: NB_BYTE];

  // All outputs are decoded from registered state only, so nothing on the
  // transmitter side (i_tx_ready) can reach an output combinationally.
  // The bank port stays selected for the whole dump, including the
  // checksum byte, so it is simply "busy".
  always_comb begin
    o_busy      = 1'b0;
    o_tx_valid  = 1'b0;
    o_tx_data   = '0;
    o_done      = 1'b0;
    case (state_q)
      ST_ADDR, ST_CAPTURE: begin
        o_busy = 1'b1;
      end
      ST_SEND: begin
        o_busy     = 1'b1;
        o_tx_valid = 1'b1;
        o_tx_data  = topByte;
      end
`ifdef REG_DUMP_CHECKSUM_EN
      ST_CHKSUM: begin
        o_busy     = 1'b1;
        o_tx_valid = 1'b1;
        o_tx_data  = chk_q;
      end
`endif
      ST_DONE: begin
        o_done = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  assign o_br_enable = o_busy;
  assign o_br_addr   = addr_q;

  // Next-state logic. The bank read has one cycle of latency, so ADDR only
  // waits and CAPTURE latches the word. In SEND a byte moves only when the
  // transmitter is ready; otherwise everything holds, which keeps o_tx_data
  // stable. Abort is applied last so it overrides a same-cycle transfer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    idx_d   = idx_q;
`ifdef REG_DUMP_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      ST_IDLE: begin
        addr_d  = '0;
        shift_d = '0;
        idx_d   = '0;
`ifdef REG_DUMP_CHECKSUM_EN
        chk_d   = '0;
`endif
        if (i_start && i_halted) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        shift_d = i_reg_data;
        idx_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (i_tx_ready) begin
          shift_d = shift_q << NB_BYTE;
`ifdef REG_DUMP_CHECKSUM_EN
          chk_d   = chk_q ^ topByte;
`endif
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (addr_q == LAST_REG) begin
`ifdef REG_DUMP_CHECKSUM_EN
              state_d = ST_CHKSUM;
`else
              state_d = ST_DONE;
`endif
            end else begin
              addr_d  = addr_q + NB_REG'(1);
              state_d = ST_ADDR;
            end
          end else begin
            idx_d = idx_q + NB_IDX'(1);
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      ST_CHKSUM: begin
        if (i_tx_ready) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        addr_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (i_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      shift_d = '0;
      idx_d   = '0;
`ifdef REG_DUMP_CHECKSUM_EN
      chk_d   = '0;
`endif
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      idx_q   <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
`ifdef REG_DUMP_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

endmodule
